// File: rtl/mar_seq_if.sv
// Bus bundle between the datapath/control side (master) and the memory address register (slave).
interface mar_seq_if #(
    parameter int ADDR_W = 4
);
    logic              mar_in;
    logic              mar_inc;
    logic              mar_mramout;
    logic [ADDR_W-1:0] data_in;
    logic              ram_ack;
    logic [ADDR_W-1:0] data_out;
    logic              addr_valid;
    logic              busy;
    logic              wrap;
    logic              overrun;

    modport master (
        output mar_in, mar_inc, mar_mramout, data_in, ram_ack,
        input  data_out, addr_valid, busy, wrap, overrun
    );

    modport slave (
        input  mar_in, mar_inc, mar_mramout, data_in, ram_ack,
        output data_out, addr_valid, busy, wrap, overrun
    );
endinterface

// File: rtl/mar_seq.sv
// Memory address register with a valid/ack presentation handshake toward RAM.
// Optional macro MAR_AUTOINC_EN: pointer auto-increments on the RAM acknowledge edge.
module mar_seq #(
    parameter int ADDR_W     = 4,
    parameter int LIMIT      = 2**ADDR_W-1,
    parameter int RESET_ADDR = 0
) (
    input  logic      clk,
    input  logic      rst,
    mar_seq_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LIMIT_V   = ADDR_W'(LIMIT);
    localparam logic [ADDR_W-1:0] RESET_V   = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W:0]   MODULUS_V = (ADDR_W+1)'(LIMIT + 1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_data_out;
    logic              r_addr_valid;
    logic              r_busy;
    logic              r_wrap;
    logic              r_overrun;

    state_e            w_state_nxt;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [ADDR_W-1:0] w_data_out_nxt;
    logic              w_addr_valid_nxt;
    logic              w_wrap_nxt;
    logic              w_overrun_nxt;
    logic              w_do_inc;
    logic [ADDR_W:0]   w_inc_res;

    // Out-of-range bus addresses fold back into 0..LIMIT.
    function automatic logic [ADDR_W-1:0] f_fold(input logic [ADDR_W-1:0] a);
        return ADDR_W'({1'b0, a} % MODULUS_V);
    endfunction

    // Returns {wrapped, next_pointer}.
    function automatic logic [ADDR_W:0] f_inc(input logic [ADDR_W-1:0] p);
        if (p == LIMIT_V) begin
            return {1'b1, {ADDR_W{1'b0}}};
        end else begin
            return {1'b0, p + ADDR_W'(1)};
        end
    endfunction

    // Pointer next value: load beats increment beats hold.
    always_comb begin
        w_ptr_nxt  = r_ptr;
        w_wrap_nxt = 1'b0;
        w_do_inc   = 1'b0;
        w_inc_res  = f_inc(r_ptr);
        if (bus.mar_in) begin
            w_ptr_nxt = f_fold(bus.data_in);
        end else if (bus.mar_inc) begin
            w_do_inc = 1'b1;
`ifdef MAR_AUTOINC_EN
        end else if ((r_state == ST_REQ) && bus.ram_ack) begin
            w_do_inc = 1'b1;
`endif
        end else begin
            w_do_inc = 1'b0;
        end
        if (w_do_inc) begin
            w_ptr_nxt  = w_inc_res[ADDR_W-1:0];
            w_wrap_nxt = w_inc_res[ADDR_W];
        end else begin
            w_wrap_nxt = 1'b0;
        end
    end

    // Handshake FSM next state and next registered outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_data_out_nxt   = r_data_out;
        w_addr_valid_nxt = 1'b0;
        w_overrun_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.mar_mramout) begin
                    // Present the pointer as it stood before this edge's update.
                    w_state_nxt      = ST_REQ;
                    w_data_out_nxt   = r_ptr;
                    w_addr_valid_nxt = 1'b1;
                end else begin
                    w_addr_valid_nxt = 1'b0;
                end
            end
            ST_REQ: begin
                w_overrun_nxt = bus.mar_mramout;
                if (bus.ram_ack) begin
                    w_state_nxt      = ST_IDLE;
                    w_addr_valid_nxt = 1'b0;
                end else begin
                    w_addr_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_addr_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= RESET_V;
            r_data_out   <= {ADDR_W{1'b0}};
            r_addr_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_wrap       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_data_out   <= w_data_out_nxt;
            r_addr_valid <= w_addr_valid_nxt;
            r_busy       <= (w_state_nxt == ST_REQ);
            r_wrap       <= w_wrap_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.addr_valid = r_addr_valid;
    assign bus.busy       = r_busy;
    assign bus.wrap       = r_wrap;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_mar_seq.sv
// Scoreboard bench for mar_seq: reference model plus queue of expected presented addresses.
module tb_mar_seq;

    logic clk;
    logic rst;

    mar_seq_if #(.ADDR_W(4)) ifc ();
    mar_seq_if #(.ADDR_W(4)) ifc9 ();

    mar_seq #(.ADDR_W(4), .LIMIT(15), .RESET_ADDR(0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    mar_seq #(.ADDR_W(4), .LIMIT(9), .RESET_ADDR(0)) u_dut9 (
        .clk (clk),
        .rst (rst),
        .bus (ifc9)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_ptr;
    logic       m_busy;
    logic       m_wrap;
    logic       m_ov;
    logic [3:0] m_dout;
    logic [3:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 4'd0;
        m_busy = 1'b0;
        m_wrap = 1'b0;
        m_ov   = 1'b0;
        m_dout = 4'd0;
        sb.delete();
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, ":valid"}, 32'(ifc.addr_valid), 32'd0);
        chk({tag, ":busy"},  32'(ifc.busy),       32'd0);
        chk({tag, ":wrap"},  32'(ifc.wrap),       32'd0);
        chk({tag, ":ovr"},   32'(ifc.overrun),    32'd0);
        chk({tag, ":dout"},  32'(ifc.data_out),   32'd0);
    endtask

    task automatic step(input logic in, input logic inc, input logic mram,
                        input logic [3:0] din, input logic ack, input string tag);
        logic [3:0] n_ptr;
        logic [3:0] n_dout;
        logic [3:0] sb_exp;
        logic       n_wrap;
        logic       n_busy;
        logic       n_ov;
        logic       a_inc;
        logic       prev_v;
        ifc.mar_in      = in;
        ifc.mar_inc     = inc;
        ifc.mar_mramout = mram;
        ifc.data_in     = din;
        ifc.ram_ack     = ack;
        n_ptr  = m_ptr;
        n_wrap = 1'b0;
        n_busy = m_busy;
        n_ov   = 1'b0;
        n_dout = m_dout;
        a_inc  = 1'b0;
`ifdef MAR_AUTOINC_EN
        a_inc  = m_busy && ack;
`endif
        if (in) begin
            n_ptr = din;
        end else if (inc || a_inc) begin
            if (m_ptr == 4'hF) begin
                n_ptr  = 4'h0;
                n_wrap = 1'b1;
            end else begin
                n_ptr = m_ptr + 4'd1;
            end
        end
        if (!m_busy) begin
            if (mram) begin
                n_busy = 1'b1;
                n_dout = m_ptr;
                sb.push_back(m_ptr);
            end
        end else begin
            n_ov = mram;
            if (ack) n_busy = 1'b0;
        end
        prev_v = ifc.addr_valid;
        @(posedge clk);
        #1;
        m_ptr  = n_ptr;
        m_wrap = n_wrap;
        m_busy = n_busy;
        m_ov   = n_ov;
        m_dout = n_dout;
        chk({tag, ":valid"}, 32'(ifc.addr_valid), 32'(m_busy));
        chk({tag, ":busy"},  32'(ifc.busy),       32'(m_busy));
        chk({tag, ":wrap"},  32'(ifc.wrap),       32'(m_wrap));
        chk({tag, ":ovr"},   32'(ifc.overrun),    32'(m_ov));
        chk({tag, ":dout"},  32'(ifc.data_out),   32'(m_dout));
        if (ifc.addr_valid && !prev_v) begin
            if (sb.size() == 0) begin
                chk({tag, ":sb_count"}, 32'(sb.size()), 32'd1);
            end else begin
                sb_exp = sb.pop_front();
                chk({tag, ":sb_addr"}, 32'(ifc.data_out), 32'(sb_exp));
            end
        end
    endtask

    task automatic step9(input logic in, input logic inc, input logic mram,
                         input logic [3:0] din, input logic ack);
        ifc9.mar_in      = in;
        ifc9.mar_inc     = inc;
        ifc9.mar_mramout = mram;
        ifc9.data_in     = din;
        ifc9.ram_ack     = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifc.mar_in = 1'b0;  ifc.mar_inc = 1'b0;  ifc.mar_mramout = 1'b0;
        ifc.data_in = 4'd0; ifc.ram_ack = 1'b0;
        ifc9.mar_in = 1'b0;  ifc9.mar_inc = 1'b0;  ifc9.mar_mramout = 1'b0;
        ifc9.data_in = 4'd0; ifc9.ram_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_chk("por");
        #3 rst = 1'b0;

        // first request after reset presents RESET_ADDR
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "rst_req");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "rst_ack");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "idle0");

        // load/present with ack two cycles later, reload underneath REQ
        step(1'b1, 1'b0, 1'b0, 4'hA, 1'b0, "ld_a");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "req_a");
        step(1'b1, 1'b0, 1'b0, 4'h8, 1'b0, "ld_8_in_req");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "ack_a");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "req_8");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "ack_8");

        // wrap at LIMIT
        step(1'b1, 1'b0, 1'b0, 4'hE, 1'b0, "ld_e");
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "inc_f");
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, "inc_wrap");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "wrap_clr");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "req_0");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "ack_0");

        // simultaneous load+request, overrun in REQ and on the ack cycle
        step(1'b1, 1'b0, 1'b0, 4'h5, 1'b0, "ld_5");
        step(1'b1, 1'b0, 1'b1, 4'h3, 1'b0, "ld3_req5");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "ovr1");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "ack5");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "req_3");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b1, "ovr_on_ack");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "ack_idle");

        // ack-edge behaviour of the pointer (auto-increment when enabled)
        step(1'b1, 1'b0, 1'b0, 4'hF, 1'b0, "ld_f");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "req_f");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "ack_f");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "req_after_f");
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, "ack_with_inc");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "req_post_inc");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "ack_post_inc");

        // randomised traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1), "rnd");
        end
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "drain1");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "drain2");

        // async reset in the middle of a request
        step(1'b1, 1'b0, 1'b0, 4'h7, 1'b0, "ld_7");
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "req_7");
        #3 rst = 1'b1;
        #1;
        rst_chk("async");
        #2 rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "req_after_rst");
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "ack_after_rst");
        chk("sb_drain", 32'(sb.size()), 32'd0);

        // LIMIT = 9 instance
        step9(1'b1, 1'b0, 1'b0, 4'd9, 1'b0);
        step9(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("l9_wrap", 32'(ifc9.wrap), 32'd1);
        step9(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        chk("l9_wrap_clr", 32'(ifc9.wrap), 32'd0);
        chk("l9_valid", 32'(ifc9.addr_valid), 32'd1);
        chk("l9_dout0", 32'(ifc9.data_out), 32'd0);
        step9(1'b1, 1'b0, 1'b0, 4'd12, 1'b1);
        chk("l9_ack", 32'(ifc9.addr_valid), 32'd0);
        step9(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        chk("l9_fold", 32'(ifc9.data_out), 32'd2);
        step9(1'b1, 1'b0, 1'b0, 4'd8, 1'b1);
        step9(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("l9_nowrap", 32'(ifc9.wrap), 32'd0);
        step9(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        chk("l9_dout9", 32'(ifc9.data_out), 32'd9);
        step9(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("l9_idle", 32'(ifc9.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mar_seq.md
Name: mar_seq

Overview:
- Parametrised memory address register for the microprocessor datapath.
- Loads an address from the bus (`mar_in`) or increments it in place (`mar_inc`).
- Presents the address to RAM through a valid/ack handshake triggered by `mar_mramout`.
- Holds the presented address stable until RAM acknowledges, while the internal pointer keeps updating underneath.

Parameters:
- `ADDR_W`, 4: address width in bits (both `data_in` and `data_out`).
- `LIMIT`, 2**ADDR_W-1: highest legal address; increment past it wraps to 0. Must be <= 2**ADDR_W-1.
- `RESET_ADDR`, 0: pointer value after reset. Must be <= `LIMIT`.

Ports:
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mar_in` input 1: load the pointer from `data_in`.
- `mar_inc` input 1: increment the pointer (wrap at `LIMIT`).
- `mar_mramout` input 1: request that the pointer be presented to RAM.
- `data_in` input `ADDR_W`: address from the bus.
- `ram_ack` input 1: RAM has consumed the presented address.
- `data_out` output `ADDR_W`: registered address to RAM.
- `addr_valid` output 1: `data_out` holds a request not yet acknowledged.
- `busy` output 1: handshake in progress (state REQ).
- `wrap` output 1: one-cycle pulse when an increment wraps `LIMIT`->0.
- `overrun` output 1: one-cycle pulse when `mar_mramout` arrives while busy.

Behaviour:
- Reset (async assert, any state):
  - pointer = `RESET_ADDR`, `data_out` = 0;
  - `addr_valid`, `busy`, `wrap`, `overrun` = 0; FSM = IDLE.
  - Reset mid-REQ abandons the request; no ack is required afterwards.
- Pointer update, every edge, priority order:
  - `mar_in`: pointer <= `data_in`. Values > `LIMIT` are truncated to `data_in` mod (`LIMIT`+1).
  - else `mar_inc`: pointer <= (pointer == `LIMIT`) ? 0 : pointer+1; `wrap` <= 1 only in the wrap case.
  - else pointer holds.
  - `wrap` is 0 on every other cycle.
- FSM has two states, IDLE and REQ.
  - IDLE, `mar_mramout`=1: `data_out` <= pointer value *before* this edge's update; `addr_valid` <= 1; go to REQ.
  - IDLE, `mar_mramout`=0: `data_out` holds its last value; `addr_valid`=0.
  - REQ: `data_out` frozen. Pointer loads/increments still take effect internally.
  - REQ, `ram_ack`=1 sampled: `addr_valid` <= 0; go to IDLE. Minimum request length 1 cycle; latency from `mar_mramout` to `addr_valid`=1 is 1 cycle.
  - REQ, `mar_mramout`=1 (including the ack cycle): request dropped, not queued; `overrun` <= 1 for one cycle.
  - A new request is accepted only in IDLE, so back-to-back requests are separated by at least one IDLE cycle.
- `busy` = (state == REQ), registered; identical timing to `addr_valid`.
- `ram_ack` while IDLE: ignored, no flag.
- All outputs are registered; no combinational input->output path.

Optional Feature:
- Macro `MAR_AUTOINC_EN`.
- Defined: on the edge where `ram_ack` is sampled in REQ, if `mar_in`=0 and `mar_inc`=0 the pointer auto-increments with the same wrap rule and `wrap` pulse. `mar_in`/`mar_inc` still win over auto-increment when asserted that cycle. Intended for sequential instruction fetch.
- Not defined: the pointer changes only via `mar_in`/`mar_inc`; `ram_ack` never touches the pointer.

Test Plan (`ADDR_W`=4, `LIMIT`=15, `RESET_ADDR`=0 unless stated):
- Reset: assert `rst` mid-cycle -> outputs 0 immediately, before the next clock edge; release, `mar_mramout` one cycle -> `data_out`=0, `addr_valid`=1 next cycle.
- Load/present: `mar_in` with `data_in`=0xA, then `mar_mramout`, `ram_ack` 2 cycles later -> `data_out`=0xA, `addr_valid` high for exactly 2 cycles, then `busy`=0.
- Stability: during REQ, `mar_in` with `data_in`=0x8 -> `data_out` stays 0xA until ack. Next request -> `data_out`=0x8.
- Wrap: load 0xE, `mar_inc` twice -> pointer 0xF then 0x0. `wrap` high for one cycle, only on the second increment. With `LIMIT`=9: load 9, `mar_inc` -> 0, `wrap`=1.
- Simultaneous/overrun: in IDLE, `mar_in`(0x3) and `mar_mramout` on the same edge, where the pointer held 0x5 -> `data_out`=0x5, pointer=0x3. `mar_mramout` again while in REQ -> `overrun` one-cycle pulse, `data_out` unchanged.
- `MAR_AUTOINC_EN`: pointer 0xF, request, ack -> pointer 0x0 and `wrap` pulses. Build without the macro -> pointer stays 0xF.
